// File: rtl/wbb_pkg.sv
// Shared types and constants for the writeback buffer.
// Latency: n/a (types only).
// Backpressure: n/a.
package wbb_pkg;

  localparam int LINE_W      = 256;
  localparam int OFFSET_BITS = 5;
  localparam int TAG_W       = 32 - OFFSET_BITS;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_FWD = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } state_e;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [LINE_W-1:0] data;
  } entry_t;

  // Byte address of the first byte of a line.
  function automatic logic [31:0] line_addr(input logic [TAG_W-1:0] tag);
    return {tag, {OFFSET_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/wbb_entry_array.sv
// Dirty-line storage with a parallel tag match across all valid entries.
// Latency: match and head read are combinational; writes/pops land next edge.
// Backpressure: none; the owning FSM decides when to write, overwrite or pop.
// Ports: lookup_tag -> hit/hit_idx/hit_data; wr_* allocates at wr_idx;
//        ow_en overwrites data at ow_idx; pop_en invalidates head_idx;
//        head_tag/head_data expose the oldest entry for draining.
module wbb_entry_array
  import wbb_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int IDX_W = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [TAG_W-1:0]  lookup_tag,
  output logic              hit,
  output logic [IDX_W-1:0]  hit_idx,
  output logic [LINE_W-1:0] hit_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [LINE_W-1:0] wr_data,
  input  logic              ow_en,
  input  logic [IDX_W-1:0]  ow_idx,
  input  logic              pop_en,
  input  logic [IDX_W-1:0]  head_idx,
  output logic [TAG_W-1:0]  head_tag,
  output logic [LINE_W-1:0] head_data
);

  entry_t entries_q [DEPTH];
  entry_t entries_d [DEPTH];

  // Index compares are done in loops so non-power-of-two depths never
  // select a nonexistent slot.
  always_comb begin
    hit       = 1'b0;
    hit_idx   = '0;
    hit_data  = '0;
    head_tag  = '0;
    head_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entries_q[i].valid && entries_q[i].tag == lookup_tag) begin
        hit      = 1'b1;
        hit_idx  = IDX_W'(i);
        hit_data = entries_q[i].data;
      end
      if (head_idx == IDX_W'(i)) begin
        head_tag  = entries_q[i].tag;
        head_data = entries_q[i].data;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entries_d[i] = entries_q[i];
      if (pop_en && head_idx == IDX_W'(i)) entries_d[i].valid = 1'b0;
      if (wr_en && wr_idx == IDX_W'(i)) begin
        entries_d[i].valid = 1'b1;
        entries_d[i].tag   = wr_tag;
        entries_d[i].data  = wr_data;
      end
      if (ow_en && ow_idx == IDX_W'(i)) entries_d[i].data = wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= entries_d[i];
    end
  end

endmodule

// File: rtl/writeback_buffer.sv
// Writeback buffer between a data cache and the line arbiter: absorbs dirty
// lines, serves read hits locally, forwards read misses, drains when idle.
// Latency: write/read hit resp 1 cycle after request seen; misses wait dfp_resp.
// Backpressure: requester holds ufp_read/ufp_write until ufp_resp; full buffer drains oldest first.
// Ports: ufp_* upstream (cache side), dfp_* downstream (arbiter side);
//        rst is asynchronous active-low.
module writeback_buffer
  import wbb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       ufp_addr,
  input  logic              ufp_read,
  input  logic              ufp_write,
  input  logic [LINE_W-1:0] ufp_wdata,
  output logic [LINE_W-1:0] ufp_rdata,
  output logic              ufp_resp,
  output logic [31:0]       dfp_addr,
  output logic              dfp_read,
  output logic              dfp_write,
  output logic [LINE_W-1:0] dfp_wdata,
  input  logic [LINE_W-1:0] dfp_rdata,
  input  logic              dfp_resp
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              dfp_read_q, dfp_read_d, dfp_write_q, dfp_write_d;
  logic [31:0]       dfp_addr_q, dfp_addr_d;
  logic [LINE_W-1:0] dfp_wdata_q, dfp_wdata_d, ufp_rdata_q, ufp_rdata_d;
  logic              ufp_resp_q, ufp_resp_d;

  logic              hit, wr_en, ow_en, pop_en;
  logic [IDX_W-1:0]  hit_idx;
  logic [LINE_W-1:0] hit_data, head_data;
  logic [TAG_W-1:0]  head_tag;
  logic [TAG_W-1:0]  lookup_tag;
  logic [OFFSET_BITS-1:0] unused_offset;

  assign lookup_tag    = ufp_addr[31:OFFSET_BITS];
  assign unused_offset = ufp_addr[OFFSET_BITS-1:0];

  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] p);
    return (p == LAST_IDX) ? '0 : p + 1'b1;
  endfunction

  wbb_entry_array #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_entries (
    .clk        (clk),
    .rst        (rst),
    .lookup_tag (lookup_tag),
    .hit        (hit),
    .hit_idx    (hit_idx),
    .hit_data   (hit_data),
    .wr_en      (wr_en),
    .wr_idx     (tail_q),
    .wr_tag     (lookup_tag),
    .wr_data    (ufp_wdata),
    .ow_en      (ow_en),
    .ow_idx     (hit_idx),
    .pop_en     (pop_en),
    .head_idx   (head_q),
    .head_tag   (head_tag),
    .head_data  (head_data)
  );

  always_comb begin
    state_d     = state_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    dfp_read_d  = dfp_read_q;
    dfp_write_d = dfp_write_q;
    dfp_addr_d  = dfp_addr_q;
    dfp_wdata_d = dfp_wdata_q;
    ufp_rdata_d = ufp_rdata_q;
    ufp_resp_d  = 1'b0;
    wr_en       = 1'b0;
    ow_en       = 1'b0;
    pop_en      = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Any upstream request wins over starting an idle drain; a write
        // into a full buffer falls through to draining the oldest line and
        // is re-evaluated here once the drain finishes.
        if (ufp_read && hit) begin
          ufp_rdata_d = hit_data;
          ufp_resp_d  = 1'b1;
          state_d     = DONE;
        end else if (ufp_read) begin
          dfp_read_d = 1'b1;
          dfp_addr_d = line_addr(lookup_tag);
          state_d    = RD_FWD;
        end else if (ufp_write && hit) begin
          ow_en      = 1'b1;
          ufp_resp_d = 1'b1;
          state_d    = DONE;
        end else if (ufp_write && count_q != DEPTH_C) begin
          wr_en      = 1'b1;
          tail_d     = next_ptr(tail_q);
          count_d    = count_q + 1'b1;
          ufp_resp_d = 1'b1;
          state_d    = DONE;
        end else if (count_q != '0) begin
          dfp_write_d = 1'b1;
          dfp_addr_d  = line_addr(head_tag);
          dfp_wdata_d = head_data;
          state_d     = DRAIN;
        end
      end
      RD_FWD: begin
        if (dfp_resp) begin
          ufp_rdata_d = dfp_rdata;
          dfp_read_d  = 1'b0;
          dfp_addr_d  = '0;
          ufp_resp_d  = 1'b1;
          state_d     = DONE;
        end
      end
      DRAIN: begin
        if (dfp_resp) begin
          pop_en      = 1'b1;
          head_d      = next_ptr(head_q);
          count_d     = count_q - 1'b1;
          dfp_write_d = 1'b0;
          dfp_addr_d  = '0;
          dfp_wdata_d = '0;
          state_d     = IDLE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      dfp_read_q  <= 1'b0;
      dfp_write_q <= 1'b0;
      dfp_addr_q  <= '0;
      dfp_wdata_q <= '0;
      ufp_rdata_q <= '0;
      ufp_resp_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      dfp_read_q  <= dfp_read_d;
      dfp_write_q <= dfp_write_d;
      dfp_addr_q  <= dfp_addr_d;
      dfp_wdata_q <= dfp_wdata_d;
      ufp_rdata_q <= ufp_rdata_d;
      ufp_resp_q  <= ufp_resp_d;
    end
  end

  assign ufp_rdata = ufp_rdata_q;
  assign ufp_resp  = ufp_resp_q;
  assign dfp_addr  = dfp_addr_q;
  assign dfp_read  = dfp_read_q;
  assign dfp_write = dfp_write_q;
  assign dfp_wdata = dfp_wdata_q;

endmodule

// File: tb/tb_writeback_buffer.sv
// Directed bench for writeback_buffer with a drain/read scoreboard and a
// downstream responder that can withhold dfp_resp.
module tb_writeback_buffer;

  logic         clk;
  logic         rst;
  logic [31:0]  ufp_addr;
  logic         ufp_read, ufp_write;
  logic [255:0] ufp_wdata, ufp_rdata;
  logic         ufp_resp;
  logic [31:0]  dfp_addr;
  logic         dfp_read, dfp_write;
  logic [255:0] dfp_wdata, dfp_rdata;
  logic         dfp_resp;

  writeback_buffer #(.DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .ufp_addr(ufp_addr), .ufp_read(ufp_read), .ufp_write(ufp_write),
    .ufp_wdata(ufp_wdata), .ufp_rdata(ufp_rdata), .ufp_resp(ufp_resp),
    .dfp_addr(dfp_addr), .dfp_read(dfp_read), .dfp_write(dfp_write),
    .dfp_wdata(dfp_wdata), .dfp_rdata(dfp_rdata), .dfp_resp(dfp_resp)
  );

  typedef struct {
    logic [31:0]  addr;
    logic [255:0] data;
  } wr_t;

  int           vectors;
  int           miscompares;
  wr_t          exp_wr[$];
  logic [255:0] exp_rd[$];
  logic [31:0]  ev_addr[$];
  bit           ev_wr[$];
  bit           hold;
  int           rd_cycles;
  int           wr_done;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [255:0] pat(input logic [31:0] a);
    return {8{a ^ 32'h5a5a_0000}};
  endfunction

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [255:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_wr.push_back(e);
  endtask

  // Downstream arbiter model: answers after three request cycles unless held.
  initial begin
    int          wait_cnt;
    bit          prev_act;
    logic [31:0] prev_addr;
    wr_t         e;
    wait_cnt  = 0;
    prev_act  = 1'b0;
    prev_addr = '0;
    dfp_resp  = 1'b0;
    dfp_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        wait_cnt = 0;
        prev_act = 1'b0;
        dfp_resp = 1'b0;
      end else begin
        chk("dfp_rw_excl", {255'd0, dfp_read & dfp_write}, 256'd0);
        chk("ufp_rw_excl", {255'd0, ufp_read & ufp_write}, 256'd0);
        if (!dfp_write) chk("dfp_wdata_idle", dfp_wdata, 256'd0);
        if (!dfp_read && !dfp_write) chk("dfp_addr_idle", {224'd0, dfp_addr}, 256'd0);
        if (dfp_read) rd_cycles++;
        if (prev_act && (dfp_read || dfp_write))
          chk("dfp_addr_stable", {224'd0, dfp_addr}, {224'd0, prev_addr});
        prev_act  = dfp_read || dfp_write;
        prev_addr = dfp_addr;
        if (dfp_resp) begin
          dfp_resp = 1'b0;
          prev_act = 1'b0;
        end else if ((dfp_read || dfp_write) && !hold) begin
          wait_cnt++;
          if (wait_cnt >= 3) begin
            wait_cnt = 0;
            dfp_resp = 1'b1;
            ev_addr.push_back(dfp_addr);
            ev_wr.push_back(dfp_write);
            if (dfp_read) begin
              dfp_rdata = pat(dfp_addr);
            end else begin
              wr_done++;
              if (exp_wr.size() == 0) begin
                e.addr = 'x;
                e.data = 'x;
              end else begin
                e = exp_wr.pop_front();
              end
              chk("drain_addr", {224'd0, dfp_addr}, {224'd0, e.addr});
              chk("drain_data", dfp_wdata, e.data);
            end
          end
        end
      end
    end
  end

  // One upstream request, held until ufp_resp; n returns cycles to resp.
  task automatic ufp_req(input bit is_wr, input logic [31:0] a, input logic [255:0] d,
                         input logic [255:0] exp_data, output int n);
    logic [255:0] e;
    bit           got;
    ufp_addr  = a;
    ufp_wdata = is_wr ? d : '0;
    ufp_write = is_wr;
    ufp_read  = !is_wr;
    if (!is_wr) exp_rd.push_back(exp_data);
    n   = 0;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (ufp_resp) begin
        got = 1'b1;
        if (!is_wr && exp_rd.size() > 0) begin
          e = exp_rd.pop_front();
          chk("ufp_rdata", ufp_rdata, e);
        end
      end
    end
    chk("ufp_resp_seen", {255'd0, got}, 256'd1);
    ufp_read  = 1'b0;
    ufp_write = 1'b0;
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(posedge clk);
      #1;
      if (exp_wr.size() == 0 && !dfp_write && !dfp_resp) done = 1'b1;
    end
    chk("drain_complete", {255'd0, done}, 256'd1);
  endtask

  initial begin
    int           n, base, rbase, resp_cnt;
    bit           seen;
    logic [255:0] da, db, dc, dd, de, df, dg, dx, dy, dz;
    da = {8{32'hAAAA_0001}}; db = {8{32'hBBBB_0002}}; dc = {8{32'hCCCC_0003}};
    dd = {8{32'hDDDD_0004}}; de = {8{32'hEEEE_0005}}; df = {8{32'hFFFF_0006}};
    dg = {8{32'h1234_0007}}; dx = {8{32'h0101_0008}}; dy = {8{32'h0202_0009}};
    dz = {8{32'h0303_000A}};
    vectors = 0; miscompares = 0; hold = 1'b0; rd_cycles = 0; wr_done = 0;
    rst = 1'b0; ufp_addr = '0; ufp_read = 1'b0; ufp_write = 1'b0; ufp_wdata = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ufp_resp", {255'd0, ufp_resp}, 256'd0);
    chk("rst_ufp_rdata", ufp_rdata, 256'd0);
    chk("rst_dfp_rw", {254'd0, dfp_read, dfp_write}, 256'd0);
    chk("rst_dfp_addr", {224'd0, dfp_addr}, 256'd0);
    chk("rst_dfp_wdata", dfp_wdata, 256'd0);
    rst = 1'b1;

    // Write into empty buffer, idle drain afterwards
    push_wr(32'h1000, da);
    base = wr_done;
    ufp_req(1'b1, 32'h1000, da, '0, n);
    chk("t1_latency", n, 1);
    chk("t1_dfp_quiet", {254'd0, dfp_read, dfp_write}, 256'd0);
    wait_drain();
    chk("t1_drain_count", wr_done - base, 1);

    // Read hit on buffered line, no downstream read
    push_wr(32'h2000, db);
    rbase = rd_cycles;
    ufp_req(1'b1, 32'h2000, db, '0, n);
    ufp_req(1'b0, 32'h2004, '0, db, n);
    chk("t2_hit_latency", n, 2);
    wait_drain();
    chk("t2_no_dfp_read", rd_cycles - rbase, 0);

    // Full buffer: third write waits for the oldest line to drain
    hold = 1'b1;
    push_wr(32'h100, dx);
    push_wr(32'h200, dy);
    push_wr(32'h300, dz);
    ufp_req(1'b1, 32'h100, dx, '0, n);
    ufp_req(1'b1, 32'h200, dy, '0, n);
    fork
      ufp_req(1'b1, 32'h300, dz, '0, n);
      begin
        repeat (10) @(posedge clk);
        #1;
        chk("t3_drain_wr", {255'd0, dfp_write}, 256'd1);
        chk("t3_drain_addr", {224'd0, dfp_addr}, {224'd0, 32'h100});
        chk("t3_no_resp", {255'd0, ufp_resp}, 256'd0);
        hold = 1'b0;
      end
    join
    chk("t3_late_resp", {255'd0, n > 12}, 256'd1);
    wait_drain();

    // Same line twice: overwrite, single drain with newest data
    hold = 1'b1;
    push_wr(32'h400, dd);
    base = wr_done;
    ufp_req(1'b1, 32'h400, dc, '0, n);
    ufp_req(1'b1, 32'h400, dd, '0, n);
    chk("t4_ow_latency", n, 2);
    hold = 1'b0;
    wait_drain();
    repeat (10) @(posedge clk);
    chk("t4_single_drain", wr_done - base, 1);

    // Read miss forwarded ahead of pending drain, aligned address
    push_wr(32'h900, de);
    base = ev_addr.size();
    ufp_req(1'b1, 32'h900, de, '0, n);
    ufp_req(1'b0, 32'h81C, '0, pat(32'h800), n);
    chk("t5_miss_latency", {255'd0, n > 3}, 256'd1);
    wait_drain();
    chk("t5_ev_count", ev_addr.size() - base, 2);
    if (ev_addr.size() >= base + 2) begin
      chk("t5_first_addr", {224'd0, ev_addr[base]}, {224'd0, 32'h800});
      chk("t5_first_is_rd", {255'd0, ev_wr[base]}, 256'd0);
      chk("t5_second_addr", {224'd0, ev_addr[base+1]}, {224'd0, 32'h900});
      chk("t5_second_is_wr", {255'd0, ev_wr[base+1]}, 256'd1);
    end

    // Reset in the middle of a drain
    hold = 1'b1;
    ufp_req(1'b1, 32'hA00, df, '0, n);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (dfp_write) seen = 1'b1;
    end
    chk("t6_drain_started", {255'd0, seen}, 256'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_rst_dfp_write", {255'd0, dfp_write}, 256'd0);
    chk("t6_rst_dfp_addr", {224'd0, dfp_addr}, 256'd0);
    chk("t6_rst_dfp_wdata", dfp_wdata, 256'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    hold = 1'b0;
    base = wr_done;
    resp_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (ufp_resp) resp_cnt++;
    end
    chk("t6_no_resp", resp_cnt, 0);
    chk("t6_no_drain", wr_done - base, 0);

    // Buffer usable again after reset
    push_wr(32'hB00, dg);
    ufp_req(1'b1, 32'hB00, dg, '0, n);
    chk("t7_latency", n, 1);
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
